// File: rtl/out_queue.sv
// Write-side front end for the seven-segment `out` block: a small request FIFO
// drained one entry per cycle, with a per-slot shadow so both halves are always driven.

module out_queue_slot (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic             half,
  input  logic [15:0]      data,
  output logic [1:0][15:0] val
);
  always_ff @(posedge clock) begin
    if (reset || clear) val <= '0;
    else if (we)        val[half] <= data;
  end
endmodule

module out_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_slot,
  input  logic                     req_half,
  input  logic [15:0]              req_data,
  input  logic                     clear,
  output logic [15:0]              outval1,
  output logic [15:0]              outval2,
  output logic [2:0]               outsel,
  output logic                     outdisplay,
  output logic [$clog2(DEPTH):0]   pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]  slot;
    logic        half;
    logic [15:0] data;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                full, empty, push, pop;
  entry_t              head, req;
  logic [7:0][1:0][15:0] shadow;

  assign full      = (pending == CW'(DEPTH));
  assign empty     = (pending == '0);
  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  assign pop       = !empty;
  assign head      = mem[rd_ptr];
  assign req       = '{slot: req_slot, half: req_half, data: req_data};

  // Storage array needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= req;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase
    end
  end

  // One shadow instance per display slot; only the popped slot is written.
  for (genvar g = 0; g < 8; g++) begin : g_slot
    out_queue_slot u_slot (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .we    (pop && (head.slot == 3'(g))),
      .half  (head.half),
      .data  (head.data),
      .val   (shadow[g])
    );
  end

  // Untouched half is carried forward from the pre-update shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      outval1    <= '0;
      outval2    <= '0;
      outsel     <= '0;
      outdisplay <= 1'b0;
    end else if (clear) begin
      outdisplay <= 1'b0;
    end else if (pop) begin
      outsel     <= head.slot;
      outval1    <= head.half ? shadow[head.slot][0] : head.data;
      outval2    <= head.half ? head.data : shadow[head.slot][1];
      outdisplay <= 1'b1;
    end else begin
      outdisplay <= 1'b0;
    end
  end
endmodule
